// File: rtl/ls374_arb_pkg.sv
// Shared types and constants for the ls374 tri-state bus arbiter.
package ls374_arb_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_TURN, ARB_DRIVE} arb_state_t;

  // All OC_b lines released; users slice off the low N_SRC bits.
  localparam int MAX_SRC = 32;
  localparam logic [MAX_SRC-1:0] OCB_ALL_OFF = '1;

endpackage

// File: rtl/ls374_bus_arbiter_rr_pick.sv
// Combinational round-robin pick: first asserted req searching upward from last+1, with wrap.
module rr_pick #(
  parameter int N_SRC = 4,
  parameter int IDXW  = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [IDXW-1:0]  last,
  output logic [IDXW-1:0]  pick,
  output logic             any
);

  logic [IDXW-1:0] idx;

  // Walk from farthest to nearest so the nearest hit after last wins.
  always_comb begin
    pick = last;
    idx  = '0;
    any  = |req;
    for (int i = N_SRC; i >= 1; i--) begin
      idx = IDXW'((int'(last) + i) % N_SRC);
      if (req[idx]) pick = idx;
    end
  end

endmodule

// File: rtl/ls374_bus_arbiter.sv
// Round-robin sequencer for ls374 drivers sharing one tri-state bus, with a
// released-bus turnaround cycle before every grant and a capture strobe at the end.
module ls374_bus_arbiter
  import ls374_arb_pkg::*;
#(
  parameter  int N_SRC       = 4,
  parameter  int HOLD_CYCLES = 2,
  localparam int IDXW        = $clog2(N_SRC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] req,
  output logic [N_SRC-1:0] oc_b,
  output logic [IDXW-1:0]  grant_idx,
  output logic             busy,
  output logic             cap,
  output logic [N_SRC-1:0] done
);

  localparam int             CW       = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [N_SRC-1:0] OCB_OFF = OCB_ALL_OFF[N_SRC-1:0];

  arb_state_t       state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [IDXW-1:0]  last, last_n, grant_n, pick;
  logic             any, busy_n, cap_n;
  logic [N_SRC-1:0] oc_b_n, done_n;

  rr_pick #(.N_SRC(N_SRC), .IDXW(IDXW)) u_pick (
    .req  (req),
    .last (last),
    .pick (pick),
    .any  (any)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    last_n  = last;
    grant_n = grant_idx;
    case (state)
      ARB_IDLE: begin
        if (any) begin
          state_n = ARB_TURN;
          grant_n = pick;
          last_n  = pick;
        end
      end
      ARB_TURN: begin
        state_n = ARB_DRIVE;
        cnt_n   = '0;
      end
      ARB_DRIVE: begin
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (any) begin
            state_n = ARB_TURN;
            grant_n = pick;
            last_n  = pick;
          end else begin
            state_n = ARB_IDLE;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = ARB_IDLE;
    endcase

    // Outputs are decoded from next-state values so they can be registered.
    oc_b_n = OCB_OFF;
    done_n = '0;
    if (state_n == ARB_DRIVE) oc_b_n[grant_n] = 1'b0;
    busy_n = (state_n != ARB_IDLE);
    cap_n  = (state_n == ARB_DRIVE) && (cnt_n == CNT_LAST);
    if (cap_n) done_n[grant_n] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      cnt       <= '0;
      last      <= IDXW'(N_SRC - 1);
      grant_idx <= '0;
      oc_b      <= OCB_OFF;
      busy      <= 1'b0;
      cap       <= 1'b0;
      done      <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      last      <= last_n;
      grant_idx <= grant_n;
      oc_b      <= oc_b_n;
      busy      <= busy_n;
      cap       <= cap_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_ls374_bus_arbiter.sv
// Randomized and directed bench for ls374_bus_arbiter against a transfer-level
// schedule model (each grant expands into one TURN cycle plus HOLD drive cycles).
module tb_ls374_bus_arbiter;

  localparam int N    = 4;
  localparam int HOLD = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'hF;
  logic [3:0] oc_b, done;
  logic [1:0] grant_idx;
  logic       busy, cap;

  int errors = 0;
  int checks = 0;
  bit inv_en = 1'b0;
  logic [3:0] prev_low = 4'h0;

  always #5 clk = ~clk;

  ls374_bus_arbiter #(.N_SRC(N), .HOLD_CYCLES(HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .oc_b      (oc_b),
    .grant_idx (grant_idx),
    .busy      (busy),
    .cap       (cap),
    .done      (done)
  );

  typedef struct packed {
    logic [3:0] ocb;
    logic [1:0] g;
    logic       busy;
    logic       cap;
    logic [3:0] done;
  } exp_t;

  exp_t q[$];
  int   m_last  = N - 1;
  int   m_grant = 0;

  function automatic exp_t mk(logic [3:0] ocb, int g, bit b, bit c, logic [3:0] d);
    exp_t e;
    e.ocb  = ocb;
    e.g    = g[1:0];
    e.busy = b;
    e.cap  = c;
    e.done = d;
    return e;
  endfunction

  function automatic exp_t obs();
    return {oc_b, grant_idx, busy, cap, done};
  endfunction

  // Applies inputs for the current cycle and returns what the DUT should show now.
  task automatic step(input logic [3:0] r, input bit rs, output exp_t e);
    int  p;
    bit  found;
    req = r;
    rst = rs;
    e = (q.size() > 0) ? q.pop_front() : mk(4'hF, m_grant, 1'b0, 1'b0, 4'h0);
    if (rs) begin
      q.delete();
      m_last  = N - 1;
      m_grant = 0;
    end else if (q.size() == 0 && r != 4'h0) begin
      found = 1'b0;
      p = 0;
      for (int k = 1; k <= N; k++) begin
        if (!found && r[(m_last + k) % N]) begin
          p = (m_last + k) % N;
          found = 1'b1;
        end
      end
      m_last  = p;
      m_grant = p;
      q.push_back(mk(4'hF, p, 1'b1, 1'b0, 4'h0));
      for (int h = 0; h < HOLD; h++)
        q.push_back(mk(~(4'b0001 << p), p, 1'b1, h == HOLD - 1,
                       (h == HOLD - 1) ? (4'b0001 << p) : 4'h0));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    exp_t e;
    for (int c = 0; c < HOLD + 4; c++) begin
      step(4'h0, 1'b0, e);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL settle cyc=%0d got=%h exp=%h", c, obs(), e);
      end
      tick();
    end
  endtask

  task automatic test_reset();
    exp_t e;
    for (int c = 0; c < 2; c++) begin
      step(4'hF, 1'b1, e);
      checks++;
      if ({oc_b, busy, cap} !== {4'hF, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d got=%h exp=%h", c, {oc_b, busy, cap}, {4'hF, 2'b00});
      end
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL reset_model cyc=%0d got=%h exp=%h", c, obs(), e);
      end
      tick();
    end
    for (int c = 0; c < 2; c++) begin
      step(4'hF, 1'b0, e);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL reset_release cyc=%0d got=%h exp=%h", c, obs(), e);
      end
      if (c == 1) begin
        checks++;
        if ({grant_idx, busy, oc_b} !== {2'd0, 1'b1, 4'hF}) begin
          errors++;
          $display("FAIL first_grant got=%h exp=%h", {grant_idx, busy, oc_b}, {2'd0, 1'b1, 4'hF});
        end
      end
      tick();
    end
  endtask

  task automatic test_single();
    exp_t e;
    logic [3:0] ocb_t  [5] = '{4'hF, 4'hF, 4'hB, 4'hB, 4'hF};
    logic       busy_t [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       cap_t  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] done_t [5] = '{4'h0, 4'h0, 4'h0, 4'h4, 4'h0};
    settle();
    for (int c = 0; c < 5; c++) begin
      step((c == 0) ? 4'b0100 : 4'b0000, 1'b0, e);
      checks++;
      if ({oc_b, busy, cap, done} !== {ocb_t[c], busy_t[c], cap_t[c], done_t[c]}) begin
        errors++;
        $display("FAIL single cyc=%0d got=%h exp=%h", c, {oc_b, busy, cap, done},
                 {ocb_t[c], busy_t[c], cap_t[c], done_t[c]});
      end
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL single_model cyc=%0d got=%h exp=%h", c, obs(), e);
      end
      tick();
    end
  endtask

  task automatic test_fairness();
    exp_t e;
    int   order[$];
    int   last_cap;
    int   exp_order[5] = '{0, 1, 2, 3, 0};
    step(4'hF, 1'b1, e);
    tick();
    last_cap = -1;
    for (int c = 0; c < 16; c++) begin
      step(4'hF, 1'b0, e);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL fair_model cyc=%0d got=%h exp=%h", c, obs(), e);
      end
      if (busy && oc_b == 4'hF) order.push_back(int'(grant_idx));
      if (cap) begin
        if (last_cap >= 0) begin
          checks++;
          if (c - last_cap != HOLD + 1) begin
            errors++;
            $display("FAIL fair_cap_period got=%0d exp=%0d", c - last_cap, HOLD + 1);
          end
        end
        last_cap = c;
      end
      tick();
    end
    checks++;
    if (order.size() < 5) begin
      errors++;
      $display("FAIL fair_turns got=%0d exp=5", order.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (order[i] != exp_order[i]) begin
          errors++;
          $display("FAIL fair_order idx=%0d got=%0d exp=%0d", i, order[i], exp_order[i]);
        end
      end
    end
  endtask

  task automatic test_regrant();
    exp_t e;
    int   turns;
    settle();
    turns = 0;
    for (int c = 0; c < 10; c++) begin
      step(4'b0010, 1'b0, e);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL regrant_model cyc=%0d got=%h exp=%h", c, obs(), e);
      end
      if (busy && oc_b == 4'hF && grant_idx == 2'd1) turns++;
      tick();
    end
    checks++;
    if (turns != 3) begin
      errors++;
      $display("FAIL regrant_turns got=%0d exp=3", turns);
    end
  endtask

  task automatic test_mid_drop();
    exp_t e;
    settle();
    for (int c = 0; c < 5; c++) begin
      step((c < 2) ? 4'b0100 : 4'b0000, 1'b0, e);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL drop_model cyc=%0d got=%h exp=%h", c, obs(), e);
      end
      if (c == 3) begin
        checks++;
        if ({cap, done} !== {1'b1, 4'b0100}) begin
          errors++;
          $display("FAIL drop_cap got=%h exp=%h", {cap, done}, {1'b1, 4'b0100});
        end
      end
      tick();
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    settle();
    for (int c = 0; c < 5; c++) begin
      step((c < 2) ? 4'b0100 : 4'b0000, c == 2, e);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL rst_mid_model cyc=%0d got=%h exp=%h", c, obs(), e);
      end
      if (c == 2) begin
        checks++;
        if (oc_b !== 4'b1011) begin
          errors++;
          $display("FAIL rst_mid_drive got=%h exp=%h", oc_b, 4'b1011);
        end
      end
      if (c == 3) begin
        checks++;
        if ({oc_b, busy, cap, done} !== {4'hF, 1'b0, 1'b0, 4'h0}) begin
          errors++;
          $display("FAIL rst_mid_abort got=%h exp=%h", {oc_b, busy, cap, done}, {4'hF, 6'h00});
        end
      end
      tick();
    end
  endtask

  task automatic test_soak();
    exp_t e;
    logic [3:0] r;
    bit rs;
    for (int c = 0; c < 400; c++) begin
      r  = 4'($urandom_range(0, 15));
      rs = ($urandom_range(0, 49) == 0);
      step(r, rs, e);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL soak cyc=%0d req=%h got=%h exp=%h", c, r, obs(), e);
      end
      tick();
    end
  endtask

  // Bus-contention and turnaround invariants, sampled off the active edge.
  always @(negedge clk) begin
    if (inv_en) begin
      checks++;
      if ($countones(~oc_b) > 1) begin
        errors++;
        $display("FAIL contention got=%h exp=at most one low bit", oc_b);
      end
      if (prev_low != 4'h0 && ~oc_b != 4'h0) begin
        checks++;
        if (~oc_b != prev_low) begin
          errors++;
          $display("FAIL turnaround got=%h exp=%h", ~oc_b, prev_low);
        end
      end
      prev_low <= ~oc_b;
    end
  end

  initial begin
    @(posedge clk);
    #1;
    inv_en = 1'b1;
    test_reset();
    test_single();
    test_fairness();
    test_regrant();
    test_mid_drop();
    test_mid_reset();
    test_soak();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
